// File: rtl/m_prog_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed program image
// over 8N1 serial and writes it word by word into instruction memory.
module m_prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_WORDS    = 4096
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_rxd,
  output logic        r_we,
  output logic [11:0] r_addr,
  output logic [31:0] r_wdata,
  output logic        r_cpu_rst,
  output logic        r_done,
  output logic        r_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_LENH, S_LENL, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  logic [1:0]    rxd_sync;
  logic          rxd_s;
  rx_state_t     rx_state, rx_nxt;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_shift;
  logic          byte_valid, frame_err;

  state_t        state, state_nxt;
  logic [15:0]   len;
  logic [12:0]   word_cnt;
  logic [1:0]    byte_cnt;
  logic [7:0]    csum;
  logic [31:0]   asm_word;
  logic          terminal;
  logic          len_ok;
  logic          last_word;

  assign rxd_s = rxd_sync[1];

  // RX next-state and single-cycle byte/framing pulses.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rx_nxt     = rx_state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rxd_s) rx_nxt = RX_START;
      RX_START: if (timer == HALF_M1) rx_nxt = rxd_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (timer == FULL_M1 && bit_cnt == 3'd7) rx_nxt = RX_STOP;
      RX_STOP: begin
        if (timer == FULL_M1) begin
          rx_nxt = RX_IDLE;
          if (rxd_s) byte_valid = 1'b1;
          else       frame_err  = 1'b1;
        end
      end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      rxd_sync <= 2'b11;
      rx_state <= RX_IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      rxd_sync <= {rxd_sync[0], w_rxd};
      rx_state <= rx_nxt;
      if (rx_state == RX_IDLE || rx_nxt != rx_state ||
          (rx_state == RX_DATA && timer == FULL_M1))
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (rx_state == RX_START) bit_cnt <= '0;
      if (rx_state == RX_DATA && timer == FULL_M1) begin
        rx_shift <= {rxd_s, rx_shift[7:1]};
        bit_cnt  <= bit_cnt + 1'b1;
      end
    end
  end

  assign terminal  = (state == S_DONE) || (state == S_ERR);
  assign len_ok    = ({len[15:8], rx_shift} != 16'd0) &&
                     (32'({len[15:8], rx_shift}) <= MAX_WORDS);
  assign last_word = (16'(word_cnt) + 16'd1 == len);

  // Loader next-state logic; terminal states ignore all further line activity.
  always_comb begin
    state_nxt = state;
    if (!terminal && frame_err) begin
      state_nxt = S_ERR;
    end else if (byte_valid) begin
      case (state)
        S_LENH:  state_nxt = S_LENL;
        S_LENL:  state_nxt = len_ok ? S_DATA : S_ERR;
        S_DATA:  if (byte_cnt == 2'd3 && last_word) state_nxt = S_CSUM;
        S_CSUM:  state_nxt = (rx_shift == csum) ? S_DONE : S_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      state     <= S_LENH;
      len       <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      csum      <= '0;
      asm_word  <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      r_we  <= 1'b0;
      if (byte_valid) begin
        case (state)
          S_LENH: begin
            len[15:8] <= rx_shift;
            csum      <= csum ^ rx_shift;
          end
          S_LENL: begin
            len[7:0] <= rx_shift;
            csum     <= csum ^ rx_shift;
          end
          S_DATA: begin
            csum     <= csum ^ rx_shift;
            asm_word <= {asm_word[23:0], rx_shift};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              r_we     <= 1'b1;
              r_wdata  <= {asm_word[23:0], rx_shift};
              r_addr   <= word_cnt[11:0];
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Flags follow the state being entered so they line up with it.
      r_cpu_rst <= (state_nxt != S_DONE);
      r_done    <= (state_nxt == S_DONE);
      r_err     <= (state_nxt == S_ERR);
    end
  end

endmodule

// File: tb/tb_m_prog_loader.sv
// Self-checking bench for m_prog_loader: bit-bangs UART streams and compares
// memory writes and status flags against a stream-level reference model.
module tb_m_prog_loader;

  localparam int CPB = 4;

  typedef logic [7:0] bq_t[$];

  logic        w_clk = 1'b0;
  logic        w_rst_n;
  logic        w_rxd;
  logic        r_we;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_cpu_rst, r_done, r_err;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] got_addr[$];
  logic [31:0] got_data[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;

  m_prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(4096)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_rxd(w_rxd),
    .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_cpu_rst(r_cpu_rst), .r_done(r_done), .r_err(r_err)
  );

  always #5 w_clk = ~w_clk;

  always @(negedge w_clk)
    if (w_rst_n === 1'b1 && r_we === 1'b1) begin
      got_addr.push_back(r_addr);
      got_data.push_back(r_wdata);
    end

  task automatic bit_out(input logic v);
    w_rxd = v;
    repeat (CPB) @(negedge w_clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    w_rxd = 1'b1;
    repeat (3 * CPB) @(negedge w_clk);
  endtask

  task automatic send_stream(input bq_t s);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_rst_n = 1'b0;
    w_rxd   = 1'b1;
    @(negedge w_clk);
    w_rst_n = 1'b1;
    got_addr.delete();
    got_data.delete();
  endtask

  // Reference: interpret the byte stream by the loader's format rules.
  task automatic build_model(input bq_t s);
    int n;
    logic [7:0] x;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'({s[0], s[1]});
    if (n < 1 || n > 4096) begin
      exp_err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_addr.push_back(w);
      exp_data.push_back({s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
    end
    x = 8'h00;
    for (int i = 0; i < 2 + 4 * n; i++) x = x ^ s[i];
    if (x == s[2+4*n]) exp_done = 1'b1;
    else               exp_err  = 1'b1;
  endtask

  task automatic test_stream_load(input string name, input bq_t s);
    build_model(s);
    send_stream(s);
    repeat (4) @(negedge w_clk);
    n_vec++;
    if (got_addr.size() !== exp_addr.size()) begin
      n_err++;
      $display("FAIL %s write count: got %0d expected %0d", name, got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      n_vec++;
      if (got_addr[i] !== 12'(exp_addr[i]) || got_data[i] !== exp_data[i]) begin
        n_err++;
        $display("FAIL %s write %0d: got (%0d,%h) expected (%0d,%h)", name, i,
                 got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    n_vec++;
    if (r_done !== exp_done || r_err !== exp_err || r_cpu_rst !== !exp_done) begin
      n_err++;
      $display("FAIL %s flags done/err/cpu_rst: got %b%b%b expected %b%b%b", name,
               r_done, r_err, r_cpu_rst, exp_done, exp_err, !exp_done);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (r_we !== 1'b0 || r_addr !== 12'd0 || r_wdata !== 32'd0 ||
        r_cpu_rst !== 1'b1 || r_done !== 1'b0 || r_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset values: got we=%b addr=%h wdata=%h cpu_rst=%b done=%b err=%b expected 0 000 00000000 1 0 0",
               r_we, r_addr, r_wdata, r_cpu_rst, r_done, r_err);
    end
  endtask

  task automatic test_single();
    bq_t s;
    s = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
    do_reset();
    send_stream(s);
    n_vec++;
    if (r_done !== 1'b0 || r_cpu_rst !== 1'b1) begin
      n_err++;
      $display("FAIL single before checksum: got done=%b cpu_rst=%b expected 0 1", r_done, r_cpu_rst);
    end
    // Checksum byte alone; the model sees the whole image.
    build_model('{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C});
    send_byte(8'h2C, 1'b1);
    repeat (4) @(negedge w_clk);
    n_vec++;
    if (got_addr.size() != 1 || got_addr[0] !== 12'd0 || got_data[0] !== exp_data[0]) begin
      n_err++;
      $display("FAIL single write: got %0d writes, first data %h expected 1 write of %h",
               got_addr.size(), (got_data.size() > 0) ? got_data[0] : 32'h0, exp_data[0]);
    end
    n_vec++;
    if (r_done !== 1'b1 || r_cpu_rst !== 1'b0 || r_err !== 1'b0) begin
      n_err++;
      $display("FAIL single flags: got done=%b cpu_rst=%b err=%b expected 1 0 0", r_done, r_cpu_rst, r_err);
    end
  endtask

  task automatic test_two_word();
    do_reset();
    test_stream_load("two_word", '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20,
                                   8'h44, 8'h00, 8'h00, 8'h00, 8'h66});
  endtask

  task automatic test_csum_err();
    do_reset();
    test_stream_load("csum_err", '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D});
  endtask

  task automatic test_len_err(input logic [7:0] hi, input logic [7:0] lo);
    do_reset();
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
    n_vec++;
    if (r_err !== 1'b1 || r_done !== 1'b0 || r_cpu_rst !== 1'b1) begin
      n_err++;
      $display("FAIL len_err %h%h after LEN_LO: got err=%b done=%b cpu_rst=%b expected 1 0 1",
               hi, lo, r_err, r_done, r_cpu_rst);
    end
    send_stream('{8'h11, 8'h22, 8'h33, 8'h44, 8'h00});
    n_vec++;
    if (got_addr.size() != 0 || r_err !== 1'b1) begin
      n_err++;
      $display("FAIL len_err %h%h terminal: got %0d writes err=%b expected 0 writes err=1",
               hi, lo, got_addr.size(), r_err);
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b0);
    send_stream('{8'h08, 8'h00, 8'h05, 8'h2C});
    n_vec++;
    if (r_err !== 1'b1 || r_done !== 1'b0 || got_addr.size() != 0) begin
      n_err++;
      $display("FAIL framing: got err=%b done=%b writes=%0d expected 1 0 0", r_err, r_done, got_addr.size());
    end
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (3) @(negedge w_clk);
    w_rxd = 1'b0;
    @(negedge w_clk);
    w_rxd = 1'b1;
    repeat (4 * CPB) @(negedge w_clk);
    test_stream_load("glitch_then_load", '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C});
  endtask

  task automatic test_midload_reset();
    do_reset();
    send_stream('{8'h00, 8'h02, 8'h00, 8'h00});
    do_reset();
    test_reset();
    test_stream_load("after_midload_reset", '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C});
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      bq_t s;
      int n;
      logic [7:0] x;
      n = int'($urandom_range(1, 4));
      s.push_back(8'h00);
      s.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
      x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      if ($urandom_range(0, 2) == 0) x = x ^ 8'(($urandom % 255) + 1);
      s.push_back(x);
      do_reset();
      test_stream_load($sformatf("random_%0d", it), s);
    end
  endtask

  initial begin
    w_rst_n = 1'b0;
    w_rxd   = 1'b1;
    repeat (3) @(negedge w_clk);
    test_reset();
    w_rst_n = 1'b1;
    test_single();
    test_two_word();
    test_csum_err();
    test_len_err(8'h00, 8'h00);
    test_len_err(8'h10, 8'h01);
    test_framing();
    test_glitch();
    test_midload_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
